// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with valid bit, stall/flush control, bubble counter and
// optional load-use hazard bubble insertion (enable with `define ID_EX_HAZARD_DETECT_EN).
module id_ex_stage_reg #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int WB_W        = 2,
  parameter int M_W         = 3,
  parameter int EX_W        = 4,
  parameter int MEMREAD_BIT = 1,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [WB_W-1:0]   ctlwb_in,
  input  logic [M_W-1:0]    ctlm_in,
  input  logic [EX_W-1:0]   ctlex_in,
  input  logic [DATA_W-1:0] npc_in,
  input  logic [DATA_W-1:0] rdata1_in,
  input  logic [DATA_W-1:0] rdata2_in,
  input  logic [DATA_W-1:0] sext_in,
  input  logic [REG_W-1:0]  rs_in,
  input  logic [REG_W-1:0]  rt_in,
  input  logic [REG_W-1:0]  rd_in,
  output logic              out_valid,
  output logic [WB_W-1:0]   wb_ctlout,
  output logic [M_W-1:0]    m_ctlout,
  output logic [EX_W-1:0]   ex_ctlout,
  output logic [DATA_W-1:0] npcout,
  output logic [DATA_W-1:0] rdata1out,
  output logic [DATA_W-1:0] rdata2out,
  output logic [DATA_W-1:0] s_extendout,
  output logic [REG_W-1:0]  rsout,
  output logic [REG_W-1:0]  rtout,
  output logic [REG_W-1:0]  rdout,
  output logic              load_use_hazard,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Handshake: in_valid marks a real instruction offered by decode; stall=1 means
  // this stage does not accept it (contents hold); out_valid marks a real
  // instruction presented to execute. A bubble (flush or hazard) overrides stall.
  logic bubble;
  logic cnt_full;

`ifdef ID_EX_HAZARD_DETECT_EN
  always_comb begin
    load_use_hazard = out_valid && m_ctlout[MEMREAD_BIT] && (rtout != '0) &&
                      ((rtout == rs_in) || (rtout == rt_in)) && in_valid;
  end
`else
  assign load_use_hazard = 1'b0;
`endif

  assign bubble   = flush | load_use_hazard;
  assign cnt_full = &bubble_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      wb_ctlout   <= '0;
      m_ctlout    <= '0;
      ex_ctlout   <= '0;
      npcout      <= '0;
      rdata1out   <= '0;
      rdata2out   <= '0;
      s_extendout <= '0;
      rsout       <= '0;
      rtout       <= '0;
      rdout       <= '0;
      bubble_cnt  <= '0;
    end else if (bubble) begin
      out_valid   <= 1'b0;
      wb_ctlout   <= '0;
      m_ctlout    <= '0;
      ex_ctlout   <= '0;
      npcout      <= '0;
      rdata1out   <= '0;
      rdata2out   <= '0;
      s_extendout <= '0;
      rsout       <= '0;
      rtout       <= '0;
      rdout       <= '0;
      if (!cnt_full) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (!stall) begin
      // An invalid slot must never write back or touch memory, so its controls load as 0.
      out_valid   <= in_valid;
      wb_ctlout   <= in_valid ? ctlwb_in : '0;
      m_ctlout    <= in_valid ? ctlm_in  : '0;
      ex_ctlout   <= in_valid ? ctlex_in : '0;
      npcout      <= npc_in;
      rdata1out   <= rdata1_in;
      rdata2out   <= rdata2_in;
      s_extendout <= sext_in;
      rsout       <= rs_in;
      rtout       <= rt_in;
      rdout       <= rd_in;
    end
  end

endmodule
